simple_axi_mst: RTL and testbench

Single-outstanding AXI4 initiator that turns one-word requests from a simple valid/ready port into single-beat AXI4 read or write transactions. It is the master-side counterpart of the simulation AXI slave models: it drives AW/W/AR, collects B/R, and returns one response per request. It sits between a core-side load/store or fetch unit and the AXI interconnect.

---
 rtl/simple_axi_mst.sv | 221 ++++++++++++++++++++++
 tb/tb_simple_axi_mst.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_mst.sv
// Single-outstanding AXI4 initiator: one valid/ready request becomes one
// single-beat AXI4 read or write, answered by one response on the resp port.
module simple_axi_mst #(
   parameter int                    AXI_ADDR_W = 64,
   parameter int                    AXI_ID_W   = 8,
   parameter int                    AXI_DATA_W = 64,
   parameter logic [AXI_ID_W-1:0]   AXI_ID     = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   // core-side request
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [AXI_ADDR_W-1:0]    req_addr,
   input  logic [2:0]               req_size,
   input  logic [AXI_DATA_W-1:0]    req_wdata,
   input  logic [AXI_DATA_W/8-1:0]  req_wstrb,
   // core-side response
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [AXI_DATA_W-1:0]    resp_rdata,
   output logic                     resp_err,
   // write address channel
   output logic                     slv_awvalid,
   input  logic                     slv_awready,
   output logic [AXI_ADDR_W-1:0]    slv_awaddr,
   output logic [2:0]               slv_awsize,
   output logic [AXI_ID_W-1:0]      slv_awid,
   output logic [7:0]               slv_awlen,
   output logic [1:0]               slv_awburst,
   output logic                     slv_awlock,
   output logic [3:0]               slv_awcache,
   output logic [2:0]               slv_awprot,
   output logic [3:0]               slv_awqos,
   output logic [3:0]               slv_awregion,
   // write data channel
   output logic                     slv_wvalid,
   input  logic                     slv_wready,
   output logic [AXI_DATA_W-1:0]    slv_wdata,
   output logic [AXI_DATA_W/8-1:0]  slv_wstrb,
   output logic                     slv_wlast,
   // write response channel
   input  logic                     slv_bvalid,
   output logic                     slv_bready,
   input  logic [AXI_ID_W-1:0]      slv_bid,
   input  logic [1:0]               slv_bresp,
   // read address channel
   output logic                     slv_arvalid,
   input  logic                     slv_arready,
   output logic [AXI_ADDR_W-1:0]    slv_araddr,
   output logic [2:0]               slv_arsize,
   output logic [AXI_ID_W-1:0]      slv_arid,
   output logic [7:0]               slv_arlen,
   output logic [1:0]               slv_arburst,
   output logic                     slv_arlock,
   output logic [3:0]               slv_arcache,
   output logic [2:0]               slv_arprot,
   output logic [3:0]               slv_arqos,
   output logic [3:0]               slv_arregion,
   // read data channel
   input  logic                     slv_rvalid,
   output logic                     slv_rready,
   input  logic [AXI_ID_W-1:0]      slv_rid,
   input  logic [1:0]               slv_rresp,
   input  logic [AXI_DATA_W-1:0]    slv_rdata,
   input  logic                     slv_rlast
);

   localparam int STRB_W = AXI_DATA_W/8;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      RESP
   } state_t;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0] addr;
      logic [2:0]            size;
      logic [AXI_DATA_W-1:0] wdata;
      logic [STRB_W-1:0]     wstrb;
   } req_t;

   state_t state, state_nxt;
   req_t   req_q;
   logic   aw_done;   // AW handshake already taken in this write
   logic   w_done;    // W handshake already taken in this write
   logic   rd_more;   // first R beat seen, still draining to rlast

   // IDs are ignored with a single transaction in flight
   logic   unused_ids;
   assign unused_ids = ^{slv_bid, slv_rid};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // All valids/readies decode from registered state so reset clears them at once
   always_comb begin
      state_nxt   = state;
      req_ready   = 1'b0;
      slv_awvalid = 1'b0;
      slv_wvalid  = 1'b0;
      slv_bready  = 1'b0;
      slv_arvalid = 1'b0;
      slv_rready  = 1'b0;
      resp_valid  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = req_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            slv_awvalid = !aw_done;
            slv_wvalid  = !w_done;
            if ((aw_done || slv_awready) && (w_done || slv_wready))
               state_nxt = WR_RESP;
         end
         WR_RESP: begin
            slv_bready = 1'b1;
            if (slv_bvalid) state_nxt = RESP;
         end
         RD_REQ: begin
            slv_arvalid = 1'b1;
            if (slv_arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            slv_rready = 1'b1;
            if (slv_rvalid && slv_rlast) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q      <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         rd_more    <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q.addr  <= req_addr;
                  req_q.size  <= req_size;
                  req_q.wdata <= req_wdata;
                  req_q.wstrb <= req_wstrb;
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
                  rd_more     <= 1'b0;
               end
            end
            WR_REQ: begin
               if (slv_awready) aw_done <= 1'b1;
               if (slv_wready)  w_done  <= 1'b1;
            end
            WR_RESP: begin
               if (slv_bvalid) begin
                  resp_rdata <= '0;
                  resp_err   <= (slv_bresp != 2'b00);
               end
            end
            RD_DATA: begin
               // Extra beats mean the slave ignored arlen=0: keep beat 0, flag error
               if (slv_rvalid) begin
                  if (!rd_more) begin
                     resp_rdata <= slv_rdata;
                     resp_err   <= (slv_rresp != 2'b00) || !slv_rlast;
                  end else begin
                     resp_err   <= resp_err || (slv_rresp != 2'b00);
                  end
                  rd_more <= !slv_rlast;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   assign slv_awaddr   = req_q.addr;
   assign slv_awsize   = req_q.size;
   assign slv_awid     = AXI_ID;
   assign slv_awlen    = 8'd0;
   assign slv_awburst  = 2'b01;
   assign slv_awlock   = 1'b0;
   assign slv_awcache  = 4'b0010;
   assign slv_awprot   = 3'b000;
   assign slv_awqos    = 4'd0;
   assign slv_awregion = 4'd0;

   assign slv_wdata    = req_q.wdata;
   assign slv_wstrb    = req_q.wstrb;
   assign slv_wlast    = 1'b1;

   assign slv_araddr   = req_q.addr;
   assign slv_arsize   = req_q.size;
   assign slv_arid     = AXI_ID;
   assign slv_arlen    = 8'd0;
   assign slv_arburst  = 2'b01;
   assign slv_arlock   = 1'b0;
   assign slv_arcache  = 4'b0010;
   assign slv_arprot   = 3'b000;
   assign slv_arqos    = 4'd0;
   assign slv_arregion = 4'd0;

endmodule

// File: tb/tb_simple_axi_mst.sv
// Directed bench for simple_axi_mst: the bench plays the AXI slave by hand,
// driving on the falling edge and checking outputs just before driving.
module tb_simple_axi_mst;
   logic        clk, rst;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr;
   logic [2:0]  req_size;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic        awvalid, awready, awlock, wvalid, wready, wlast;
   logic [63:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic [7:0]  awid, awlen, arid, arlen, wstrb, bid, rid;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion;
   logic        bvalid, bready, arvalid, arready, arlock, rvalid, rready, rlast;

   int checks = 0;
   int failures = 0;

   simple_axi_mst dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .slv_awvalid(awvalid), .slv_awready(awready), .slv_awaddr(awaddr), .slv_awsize(awsize),
      .slv_awid(awid), .slv_awlen(awlen), .slv_awburst(awburst), .slv_awlock(awlock),
      .slv_awcache(awcache), .slv_awprot(awprot), .slv_awqos(awqos), .slv_awregion(awregion),
      .slv_wvalid(wvalid), .slv_wready(wready), .slv_wdata(wdata), .slv_wstrb(wstrb), .slv_wlast(wlast),
      .slv_bvalid(bvalid), .slv_bready(bready), .slv_bid(bid), .slv_bresp(bresp),
      .slv_arvalid(arvalid), .slv_arready(arready), .slv_araddr(araddr), .slv_arsize(arsize),
      .slv_arid(arid), .slv_arlen(arlen), .slv_arburst(arburst), .slv_arlock(arlock),
      .slv_arcache(arcache), .slv_arprot(arprot), .slv_arqos(arqos), .slv_arregion(arregion),
      .slv_rvalid(rvalid), .slv_rready(rready), .slv_rid(rid), .slv_rresp(rresp),
      .slv_rdata(rdata), .slv_rlast(rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      req_valid = 0; req_write = 0; req_addr = '0; req_size = '0;
      req_wdata = '0; req_wstrb = '0; resp_ready = 0;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bid = '0; bresp = '0;
      rvalid = 0; rid = '0; rresp = '0; rdata = '0; rlast = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      #2;
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err} !== 7'b0) begin
         failures++; $display("FAIL reset_valids got=%b exp=0",
            {awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err});
      end
      checks++;
      if (resp_rdata !== 64'd0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
      end
      @(negedge clk); @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_read();
      req_valid = 1; req_write = 0; req_addr = 64'h8000_0010; req_size = 3;
      @(negedge clk);                       // accepted at the edge just passed
      req_valid = 0;
      checks++;
      if ({arvalid, awvalid, req_ready} !== 3'b100 || araddr !== 64'h8000_0010) begin
         failures++; $display("FAIL rd_ar got=%b/%h exp=100/8000_0010", {arvalid, awvalid, req_ready}, araddr);
      end
      checks++;
      if (arlen !== 8'd0 || arsize !== 3'd3 || arburst !== 2'b01 || arcache !== 4'b0010 || arid !== 8'd0) begin
         failures++; $display("FAIL rd_ar_fields got=%h %h %b %b %h", arlen, arsize, arburst, arcache, arid);
      end
      arready = 1;
      @(negedge clk);
      arready = 0;
      checks++;
      if ({arvalid, rready, resp_valid} !== 3'b010) begin
         failures++; $display("FAIL rd_rready got=%b exp=010", {arvalid, rready, resp_valid});
      end
      rvalid = 1; rdata = 64'hDEAD_BEEF_0123_4567; rresp = 0; rlast = 1;
      @(negedge clk);
      rvalid = 0; rlast = 0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEAD_BEEF_0123_4567 || resp_err !== 1'b0) begin
         failures++; $display("FAIL rd_resp got=%b %h %b exp=1 deadbeef01234567 0", resp_valid, resp_rdata, resp_err);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         failures++; $display("FAIL rd_done got=%b exp=01", {resp_valid, req_ready});
      end
   endtask

   task automatic test_write_skew();
      req_valid = 1; req_write = 1; req_addr = 64'h4000; req_size = 3;
      req_wdata = 64'h1122_3344_5566_7788; req_wstrb = 8'h0F;
      @(negedge clk);
      req_valid = 0;
      checks++;
      if ({awvalid, wvalid, wlast, arvalid} !== 4'b1110 || wdata !== 64'h1122_3344_5566_7788 || wstrb !== 8'h0F) begin
         failures++; $display("FAIL wr_issue got=%b %h %h", {awvalid, wvalid, wlast, arvalid}, wdata, wstrb);
      end
      wready = 1;
      @(negedge clk);
      wready = 0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 64'h4000) begin
            failures++; $display("FAIL wr_skew_%0d got=%b %h exp=100 4000", i, {awvalid, wvalid, bready}, awaddr);
         end
         @(negedge clk);
      end
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b100) begin
         failures++; $display("FAIL wr_skew_2 got=%b exp=100", {awvalid, wvalid, bready});
      end
      awready = 1;                          // 3 edges after the W handshake
      @(negedge clk);
      awready = 0;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         failures++; $display("FAIL wr_bready got=%b exp=001", {awvalid, wvalid, bready});
      end
      bvalid = 1; bresp = 2'b10;
      @(negedge clk);
      bvalid = 0; bresp = 0;
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin
         failures++; $display("FAIL wr_resp got=%b %b %h exp=1 1 0", resp_valid, resp_err, resp_rdata);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
   endtask

   task automatic test_read_burst_err();
      req_valid = 1; req_write = 0; req_addr = 64'h200; req_size = 3;
      @(negedge clk);
      req_valid = 0; arready = 1;
      @(negedge clk);
      arready = 0;
      rvalid = 1; rdata = 64'hAA; rresp = 0; rlast = 0;
      @(negedge clk);
      checks++;
      if ({rready, resp_valid} !== 2'b10) begin
         failures++; $display("FAIL burst_beat2_rready got=%b exp=10", {rready, resp_valid});
      end
      rdata = 64'hBB; rlast = 1;
      @(negedge clk);
      rvalid = 0; rlast = 0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hAA || resp_err !== 1'b1) begin
         failures++; $display("FAIL burst_resp got=%b %h %b exp=1 aa 1", resp_valid, resp_rdata, resp_err);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
   endtask

   task automatic test_backpressure();
      req_valid = 1; req_write = 0; req_addr = 64'h300; req_size = 2;
      @(negedge clk);
      req_valid = 0; arready = 1;
      @(negedge clk);
      arready = 0; rvalid = 1; rdata = 64'h0BAD_F00D; rresp = 0; rlast = 1;
      @(negedge clk);
      rvalid = 0; rlast = 0;
      req_valid = 1; req_write = 1; req_addr = 64'h999;   // must not be taken
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({resp_valid, req_ready, arvalid, awvalid} !== 4'b1000 || resp_rdata !== 64'h0BAD_F00D || resp_err !== 1'b0) begin
            failures++; $display("FAIL bp_hold_%0d got=%b %h %b", i, {resp_valid, req_ready, arvalid, awvalid}, resp_rdata, resp_err);
         end
         @(negedge clk);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0; req_valid = 0;
      checks++;
      if ({resp_valid, req_ready, arvalid, awvalid} !== 4'b0100) begin
         failures++; $display("FAIL bp_release got=%b exp=0100", {resp_valid, req_ready, arvalid, awvalid});
      end
   endtask

   task automatic test_hung();
      req_valid = 1; req_write = 0; req_addr = 64'h400; req_size = 3;
      @(negedge clk);
      req_valid = 0;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({arvalid, req_ready} !== 2'b10) begin
            failures++; $display("FAIL hung_%0d got=%b exp=10", i, {arvalid, req_ready});
         end
         @(negedge clk);
      end
      #2 rst = 1; idle_inputs();           // mid-cycle: must act without a clock edge
      #1;
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, resp_valid} !== 6'b0) begin
         failures++; $display("FAIL hung_async_rst got=%b exp=0", {awvalid, wvalid, arvalid, bready, rready, resp_valid});
      end
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, arvalid} !== 3'b100 || resp_rdata !== 64'd0) begin
         failures++; $display("FAIL hung_after_rst got=%b %h exp=100 0", {req_ready, resp_valid, arvalid}, resp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int nresp = 0;
      awready = 1; wready = 1; arready = 1;
      req_valid = 1; req_write = 1; req_addr = 64'h100; req_size = 3;
      req_wdata = 64'h55; req_wstrb = 8'hFF;
      @(negedge clk);
      req_write = 0;                        // read request waits behind the write
      checks++;
      if ({awvalid, wvalid, arvalid, req_ready} !== 4'b1100) begin
         failures++; $display("FAIL b2b_wr got=%b exp=1100", {awvalid, wvalid, arvalid, req_ready});
      end
      @(negedge clk);
      checks++;
      if ({awvalid, arvalid, bready} !== 3'b001) begin
         failures++; $display("FAIL b2b_bready got=%b exp=001", {awvalid, arvalid, bready});
      end
      bvalid = 1; bresp = 0;
      @(negedge clk);
      bvalid = 0;
      if (resp_valid === 1'b1) nresp++;
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'd0 || arvalid !== 1'b0) begin
         failures++; $display("FAIL b2b_wr_resp got=%b %b %h %b", resp_valid, resp_err, resp_rdata, arvalid);
      end
      resp_ready = 1;
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, awvalid, arvalid} !== 4'b1000) begin
         failures++; $display("FAIL b2b_gap got=%b exp=1000", {req_ready, resp_valid, awvalid, arvalid});
      end
      @(negedge clk);
      req_valid = 0;
      checks++;
      if ({arvalid, awvalid} !== 2'b10 || araddr !== 64'h100) begin
         failures++; $display("FAIL b2b_ar got=%b %h exp=10 100", {arvalid, awvalid}, araddr);
      end
      @(negedge clk);
      rvalid = 1; rdata = 64'h55; rresp = 0; rlast = 1;
      @(negedge clk);
      rvalid = 0; rlast = 0;
      if (resp_valid === 1'b1) nresp++;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h55 || resp_err !== 1'b0) begin
         failures++; $display("FAIL b2b_rd_resp got=%b %h %b exp=1 55 0", resp_valid, resp_rdata, resp_err);
      end
      @(negedge clk);
      resp_ready = 0;
      if (resp_valid === 1'b1) nresp++;
      checks++;
      if (nresp !== 2) begin
         failures++; $display("FAIL b2b_count got=%0d exp=2", nresp);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_skew();
      test_read_burst_err();
      test_backpressure();
      test_hung();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
